// File: rtl/io_input_conditioner.sv
// Input conditioner for the memory-mapped I/O region: synchronises and debounces switch and
// button pins, captures button presses in sticky W1C bits and raises a maskable interrupt.
module io_input_conditioner #(
   parameter int unsigned N_SW           = 32,
   parameter int unsigned N_BTN          = 4,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned DB_CYCLES      = 16,
   parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [N_SW-1:0]   i_io_sw,
   input  logic [N_BTN-1:0]  i_io_btn,
   input  logic [3:0]        i_addr,
   input  logic              i_wr_en,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata,
   output logic [N_SW-1:0]   o_sw,
   output logic [N_BTN-1:0]  o_btn,
   output logic              o_irq
);

   localparam int unsigned NCH = N_SW + N_BTN;
   localparam int unsigned CW  = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DbLast = CW'(DB_CYCLES - 1);

   // Switches occupy the low channels, buttons the high ones.
   logic [N_BTN-1:0] btn_pin;
   logic [NCH-1:0]   pin_vec;
   assign btn_pin = BTN_ACTIVE_LOW ? ~i_io_btn : i_io_btn;
   assign pin_vec = {btn_pin, i_io_sw};

   logic [NCH-1:0] sync_q [SYNC_STAGES];
   logic [NCH-1:0] synced;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= pin_vec;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   logic [CW-1:0]  cnt_q [NCH];
   logic [CW-1:0]  cnt_d [NCH];
   logic [NCH-1:0] stable_q, stable_d;

   // Any sample equal to the stable level clears the run of differing samples.
   always_comb begin
      stable_d = stable_q;
      for (int c = 0; c < NCH; c++) begin
         cnt_d[c] = '0;
         if (synced[c] != stable_q[c]) begin
            if (cnt_q[c] == DbLast) begin
               stable_d[c] = synced[c];
            end else begin
               cnt_d[c] = cnt_q[c] + CW'(1);
            end
         end
      end
   end

   logic [1:0]       sel;
   logic             wr_edge, wr_irq_en;
   logic [N_BTN-1:0] press, edge_clr;
   logic [N_BTN-1:0] edge_q, edge_d;
   logic [N_BTN-1:0] irq_en_q, irq_en_d;
   logic             irq_d;

   assign sel       = i_addr[3:2];
   assign wr_edge   = i_wr_en && (sel == 2'd2);
   assign wr_irq_en = i_wr_en && (sel == 2'd3);
   assign press     = stable_d[NCH-1:N_SW] & ~stable_q[NCH-1:N_SW];
   assign edge_clr  = wr_edge ? i_wdata[N_BTN-1:0] : '0;

   // A press in the same cycle as a clear of that bit keeps the bit set.
   assign edge_d   = (edge_q & ~edge_clr) | press;
   assign irq_en_d = wr_irq_en ? i_wdata[N_BTN-1:0] : irq_en_q;
   assign irq_d    = |(edge_d & irq_en_d);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
         stable_q <= '0;
         edge_q   <= '0;
         irq_en_q <= '0;
         o_irq    <= 1'b0;
      end else begin
         for (int c = 0; c < NCH; c++) cnt_q[c] <= cnt_d[c];
         stable_q <= stable_d;
         edge_q   <= edge_d;
         irq_en_q <= irq_en_d;
         o_irq    <= irq_d;
      end
   end

   assign o_sw  = stable_q[N_SW-1:0];
   assign o_btn = stable_q[NCH-1:N_SW];

   always_comb begin
      o_rdata = '0;
      case (sel)
         2'd0:    o_rdata[N_SW-1:0]  = o_sw;
         2'd1:    o_rdata[N_BTN-1:0] = o_btn;
         2'd2:    o_rdata[N_BTN-1:0] = edge_q;
         default: o_rdata[N_BTN-1:0] = irq_en_q;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{i_addr[1:0], i_wdata};

endmodule
